// File: rtl/multdiv_ctrl.sv
// -----------------------------------------------------------------------------
// multdiv_ctrl
//
// Sequencer for the shared iterative multiply/divide unit in the execute stage.
// A one-cycle start pulse loads the datapath registers. The controller then
// enables either the radix-4 Booth product register (shift right by 2) or the
// restoring-divider remainder register (shift left by 1) for the operation's
// iteration count. It then pulses data_resultRDY for one cycle. Divide-by-zero
// skips the iterations and raises data_exception together with data_resultRDY.
//
// Ports
//   clock          : rising-edge system clock
//   reset          : asynchronous, active-low; forces IDLE and all outputs low
//   ctrl_MULT      : start multiply (one-cycle pulse); wins over ctrl_DIV
//   ctrl_DIV       : start divide (one-cycle pulse)
//   flush          : pipeline flush; aborts any operation and drops a start
//   data_operandB  : divisor/multiplier, zero-checked on the accepting edge
//   load_ena       : datapath loads the initial product/remainder register
//   reg_ena        : clock enable of the datapath registers
//   mult_shift_ena : shift enable of the product register
//   div_shift_ena  : shift enable of the remainder register
//   op_is_div      : result mux select (1 = divider, 0 = multiplier)
//   busy           : stall request to the pipeline
//   data_resultRDY : result valid, one-cycle pulse
//   data_exception : divide-by-zero, meaningful only with data_resultRDY
//
// All outputs are decoded from registered state; none depends on an input
// in the same cycle.
// -----------------------------------------------------------------------------
module multdiv_ctrl #(
  parameter int MULT_ITERS = 16,
  parameter int DIV_ITERS  = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic        flush,
  input  logic [31:0] data_operandB,
  output logic        load_ena,
  output logic        reg_ena,
  output logic        mult_shift_ena,
  output logic        div_shift_ena,
  output logic        op_is_div,
  output logic        busy,
  output logic        data_resultRDY,
  output logic        data_exception
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [5:0] MULT_LAST = 6'(MULT_ITERS - 1);
  localparam logic [5:0] DIV_LAST  = 6'(DIV_ITERS - 1);

  state_t     state;
  state_t     state_next;
  logic [5:0] count;
  logic       op;     // latched operation: 1 = divide
  logic       zero;   // latched data_operandB == 0
  logic       start;
  logic       accept;
  logic       last_iter;

  assign start     = ctrl_MULT | ctrl_DIV;
  // A start is accepted only from IDLE or DONE (back-to-back issue), and a
  // simultaneous flush drops it.
  assign accept    = start & ~flush & ((state == IDLE) | (state == DONE));
  assign last_iter = (count == (op ? DIV_LAST : MULT_LAST));

  // The latched op doubles as the result mux select. It changes only on an
  // accepting edge, so the select stays stable after the result pulse.
  assign op_is_div = op;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and process ordering cannot matter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= 6'd0;
      op    <= 1'b0;
      zero  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        op   <= ~ctrl_MULT;
        zero <= (data_operandB == 32'd0);
      end
      if (state == LOAD) begin
        count <= 6'd0;
      end else if (state == RUN) begin
        count <= count + 6'd1;
      end
    end
  end

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = (op && zero) ? DONE : RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    state_next = start ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
    // Flush overrides everything, including a start sampled in the same cycle.
    if (flush) state_next = IDLE;
  end

  always_comb begin
    load_ena       = 1'b0;
    reg_ena        = 1'b0;
    mult_shift_ena = 1'b0;
    div_shift_ena  = 1'b0;
    busy           = 1'b0;
    data_resultRDY = 1'b0;
    data_exception = 1'b0;
    unique case (state)
      IDLE: ;
      LOAD: begin
        load_ena = 1'b1;
        reg_ena  = 1'b1;
        busy     = 1'b1;
      end
      RUN: begin
        reg_ena        = 1'b1;
        mult_shift_ena = ~op;
        div_shift_ena  = op;
        busy           = 1'b1;
      end
      DONE: begin
        data_resultRDY = 1'b1;
        data_exception = op & zero;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multdiv_ctrl
//
// Directed bench for multdiv_ctrl. Inputs change on the falling edge and are
// sampled by the DUT on the rising edge. Outputs are read on the falling edge.
// "Edge i" below counts rising edges after the edge that accepted the start
// (i = 0 is the accepting edge itself, where LOAD becomes visible).
// -----------------------------------------------------------------------------
module tb_multdiv_ctrl;

  logic        clock;
  logic        reset;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic        flush;
  logic [31:0] data_operandB;
  logic        load_ena;
  logic        reg_ena;
  logic        mult_shift_ena;
  logic        div_shift_ena;
  logic        op_is_div;
  logic        busy;
  logic        data_resultRDY;
  logic        data_exception;

  int checks = 0;
  int errors = 0;

  multdiv_ctrl #(
    .MULT_ITERS(16),
    .DIV_ITERS (32)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .flush         (flush),
    .data_operandB (data_operandB),
    .load_ena      (load_ena),
    .reg_ena       (reg_ena),
    .mult_shift_ena(mult_shift_ena),
    .div_shift_ena (div_shift_ena),
    .op_is_div     (op_is_div),
    .busy          (busy),
    .data_resultRDY(data_resultRDY),
    .data_exception(data_exception)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Observation record filled by observe().
  int   rdy_edge;
  int   n_load, n_mshift, n_dshift, n_busy, n_reg;
  logic exc;

  // Call on a falling edge. Drives a start for one rising edge and returns on
  // the following falling edge.
  task automatic issue(input logic m, input logic d, input logic [31:0] b);
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandB = b;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  // Samples outputs once per cycle, starting at the current falling edge
  // (index 0), until data_resultRDY is seen or max_cycles have passed.
  // rdy_edge stays -1 if no result pulse appears. If inj >= 0, a stray
  // ctrl_MULT pulse is driven for the edge that follows sample inj.
  task automatic observe(input int max_cycles, input int inj);
    rdy_edge = -1;
    n_load = 0; n_mshift = 0; n_dshift = 0; n_busy = 0; n_reg = 0;
    exc = 1'b0;
    for (int i = 0; i <= max_cycles; i++) begin
      n_load   += int'(load_ena);
      n_mshift += int'(mult_shift_ena);
      n_dshift += int'(div_shift_ena);
      n_busy   += int'(busy);
      n_reg    += int'(reg_ena);
      if (data_resultRDY) begin
        rdy_edge = i;
        exc      = data_exception;
        break;
      end
      if (i == inj) ctrl_MULT = 1'b1;
      @(negedge clock);
      ctrl_MULT = 1'b0;
    end
  endtask

  function automatic logic [7:0] outs();
    return {load_ena, reg_ena, mult_shift_ena, div_shift_ena,
            op_is_div, busy, data_resultRDY, data_exception};
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; flush = 1'b0; data_operandB = 32'd0;
    #1 reset = 1'b0;
    #1;
    checks++;
    if (outs() !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got %b want %b", outs(), 8'h00);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (outs() !== 8'h00) begin
      errors++;
      $display("FAIL idle_after_reset got %b want %b", outs(), 8'h00);
    end
  endtask

  task automatic test_multiply;
    issue(1'b1, 1'b0, 32'd7);
    checks++;
    if (op_is_div !== 1'b0) begin
      errors++; $display("FAIL mul_op_is_div got %b want 0", op_is_div);
    end
    observe(40, -1);
    checks++;
    if (rdy_edge != 17) begin
      errors++; $display("FAIL mul_rdy_edge got %0d want 17", rdy_edge);
    end
    checks++;
    if (n_load != 1) begin
      errors++; $display("FAIL mul_load_cycles got %0d want 1", n_load);
    end
    checks++;
    if (n_mshift != 16) begin
      errors++; $display("FAIL mul_shift_cycles got %0d want 16", n_mshift);
    end
    checks++;
    if (n_dshift != 0) begin
      errors++; $display("FAIL mul_div_shift_cycles got %0d want 0", n_dshift);
    end
    checks++;
    if (exc !== 1'b0) begin
      errors++; $display("FAIL mul_exception got %b want 0", exc);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL mul_busy_in_done got %b want 0", busy);
    end
    @(negedge clock);
    checks++;
    if ({data_resultRDY, busy} !== 2'b00) begin
      errors++;
      $display("FAIL mul_rdy_pulse_width got rdy,busy=%b want 00", {data_resultRDY, busy});
    end
    // A zero multiplier is an ordinary multiply.
    issue(1'b1, 1'b0, 32'd0);
    observe(40, -1);
    checks++;
    if ({rdy_edge, n_mshift, 31'd0, exc} !== {32'd17, 32'd16, 32'd0}) begin
      errors++;
      $display("FAIL mul_zero_operand got edge=%0d shifts=%0d exc=%b want 17 16 0",
               rdy_edge, n_mshift, exc);
    end
    @(negedge clock);
  endtask

  task automatic test_divide;
    issue(1'b0, 1'b1, 32'd3);
    checks++;
    if (op_is_div !== 1'b1) begin
      errors++; $display("FAIL div_op_is_div got %b want 1", op_is_div);
    end
    observe(50, -1);
    checks++;
    if (rdy_edge != 33) begin
      errors++; $display("FAIL div_rdy_edge got %0d want 33", rdy_edge);
    end
    checks++;
    if (n_dshift != 32) begin
      errors++; $display("FAIL div_shift_cycles got %0d want 32", n_dshift);
    end
    checks++;
    if (n_mshift != 0) begin
      errors++; $display("FAIL div_mult_shift_cycles got %0d want 0", n_mshift);
    end
    checks++;
    if (n_busy != 33) begin
      errors++; $display("FAIL div_busy_cycles got %0d want 33", n_busy);
    end
    checks++;
    if (n_reg != 33) begin
      errors++; $display("FAIL div_reg_ena_cycles got %0d want 33", n_reg);
    end
    checks++;
    if (exc !== 1'b0) begin
      errors++; $display("FAIL div_exception got %b want 0", exc);
    end
    @(negedge clock);
  endtask

  task automatic test_div_by_zero;
    issue(1'b0, 1'b1, 32'd0);
    observe(10, -1);
    checks++;
    if (rdy_edge != 1) begin
      errors++; $display("FAIL dbz_rdy_edge got %0d want 1", rdy_edge);
    end
    checks++;
    if (exc !== 1'b1) begin
      errors++; $display("FAIL dbz_exception got %b want 1", exc);
    end
    checks++;
    if (n_mshift + n_dshift != 0) begin
      errors++; $display("FAIL dbz_shift_cycles got %0d want 0", n_mshift + n_dshift);
    end
    checks++;
    if (n_load != 1) begin
      errors++; $display("FAIL dbz_load_cycles got %0d want 1", n_load);
    end
    @(negedge clock);
    checks++;
    if (data_exception !== 1'b0) begin
      errors++; $display("FAIL dbz_exception_after got %b want 0", data_exception);
    end
  endtask

  task automatic test_flush;
    // Both starts together: multiply wins.
    issue(1'b1, 1'b1, 32'd5);
    checks++;
    if ({load_ena, op_is_div} !== 2'b10) begin
      errors++;
      $display("FAIL collision_mult_wins got load,op=%b want 10", {load_ena, op_is_div});
    end
    repeat (4) @(negedge clock);  // now in RUN cycle 4
    checks++;
    if (mult_shift_ena !== 1'b1) begin
      errors++; $display("FAIL flush_pre_run got %b want 1", mult_shift_ena);
    end
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    checks++;
    if (outs() !== 8'h00) begin
      errors++; $display("FAIL flush_to_idle got %b want %b", outs(), 8'h00);
    end
    observe(25, -1);
    checks++;
    if (rdy_edge != -1) begin
      errors++; $display("FAIL flush_no_rdy got edge %0d want none", rdy_edge);
    end
    // Flush together with a start in IDLE: the start is dropped.
    flush = 1'b1;
    issue(1'b0, 1'b1, 32'd0);
    flush = 1'b0;
    checks++;
    if ({busy, load_ena, op_is_div} !== 3'b000) begin
      errors++;
      $display("FAIL flush_drops_start got busy,load,op=%b want 000",
               {busy, load_ena, op_is_div});
    end
    observe(5, -1);
    checks++;
    if (rdy_edge != -1) begin
      errors++; $display("FAIL flush_start_no_rdy got edge %0d want none", rdy_edge);
    end
  endtask

  task automatic test_back_to_back;
    issue(1'b1, 1'b0, 32'd2);
    observe(40, -1);
    checks++;
    if (rdy_edge != 17) begin
      errors++; $display("FAIL b2b_mul_rdy_edge got %0d want 17", rdy_edge);
    end
    // Start a divide in the multiply's DONE cycle.
    issue(1'b0, 1'b1, 32'd9);
    checks++;
    if ({load_ena, busy, op_is_div} !== 3'b111) begin
      errors++;
      $display("FAIL b2b_load got load,busy,op=%b want 111", {load_ena, busy, op_is_div});
    end
    // Stray ctrl_MULT during RUN must be ignored.
    observe(50, 5);
    checks++;
    if (rdy_edge != 33) begin
      errors++; $display("FAIL b2b_div_rdy_edge got %0d want 33", rdy_edge);
    end
    checks++;
    if ({n_load, n_dshift, n_mshift} !== {32'd1, 32'd32, 32'd0}) begin
      errors++;
      $display("FAIL b2b_div_cycles got load=%0d dshift=%0d mshift=%0d want 1 32 0",
               n_load, n_dshift, n_mshift);
    end
    @(negedge clock);
    checks++;
    if ({op_is_div, busy} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_op_hold got op,busy=%b want 10", {op_is_div, busy});
    end
  endtask

  task automatic test_reset_mid_run;
    issue(1'b0, 1'b1, 32'd3);
    repeat (5) @(negedge clock);
    checks++;
    if (div_shift_ena !== 1'b1) begin
      errors++; $display("FAIL rst_pre_run got %b want 1", div_shift_ena);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (outs() !== 8'h00) begin
      errors++; $display("FAIL rst_mid_run got %b want %b", outs(), 8'h00);
    end
    @(negedge clock);
    reset = 1'b1;
    observe(40, -1);
    checks++;
    if ({rdy_edge, n_busy} !== {-32'sd1, 32'd0}) begin
      errors++;
      $display("FAIL rst_no_rdy got edge=%0d busy_cycles=%0d want none 0", rdy_edge, n_busy);
    end
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_divide();
    test_div_by_zero();
    test_flush();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
